ysyx_23060124_wbu: RTL and testbench

Write-back stage of the ysyx_23060124 core, directly downstream of the EXU→WBU pipeline register. It accepts one executed instruction per handshake and commits it:
- GPR write
- CSR write, including the two-step ecall trap update of mepc then mcause
- PC redirect to the IFU (branch/jump/trap/mret)
- retired-instruction count

All outputs are driven only from internal registers; there is no combinational input-to-output path.

---
 rtl/ysyx_23060124_wbu.sv | 103 ++++++++++
 tb/tb_ysyx_23060124_wbu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_wbu.sv
// ysyx_23060124_wbu: write-back stage committing GPR/CSR writes, PC redirects and retire count
module ysyx_23060124_wbu #(
  parameter int          DATA_W      = 32,
  parameter int          CNT_W       = 64,
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_pc_next,
  input  logic              i_pc_update,
  input  logic [4:0]        i_rd,
  input  logic [DATA_W-1:0] i_rd_wdata,
  input  logic              i_wen,
  input  logic [11:0]       i_csr_addr,
  input  logic [DATA_W-1:0] i_csr_wdata,
  input  logic              i_csr_wen,
  input  logic              i_ecall,
  input  logic              i_mret,
  input  logic [DATA_W-1:0] i_mtvec,
  input  logic [DATA_W-1:0] i_mepc,
  output logic              o_gpr_wen,
  output logic [4:0]        o_gpr_waddr,
  output logic [DATA_W-1:0] o_gpr_wdata,
  output logic              o_csr_wen,
  output logic [11:0]       o_csr_waddr,
  output logic [DATA_W-1:0] o_csr_wdata,
  output logic              o_pc_valid,
  output logic [DATA_W-1:0] o_pc,
  output logic              o_retire,
  output logic [CNT_W-1:0]  o_retire_cnt
);
  typedef enum logic [1:0] {IDLE, COMMIT, TRAP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] pc_q, pc_next_q, rd_wdata_q, csr_wdata_q, mtvec_q, mepc_q;
  logic [4:0]        rd_q;
  logic [11:0]       csr_addr_q;
  logic              pc_update_q, wen_q, csr_wen_q, ecall_q, mret_q;
  logic [CNT_W-1:0]  retire_cnt;
  logic              xfer, commit, trap, cnt_inc;
  assign commit       = state == COMMIT;
  assign trap         = state == TRAP;
  assign o_ready      = (state == IDLE) || (commit && !ecall_q);
  assign xfer         = i_valid && o_ready;
  // counter is bumped on the edge entering the retiring cycle so the output already shows it
  assign cnt_inc      = (xfer && !i_ecall) || (commit && ecall_q);
  assign o_retire_cnt = retire_cnt;
  // state register, field latches and retire counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc_q        <= '0;
      pc_next_q   <= '0;
      pc_update_q <= 1'b0;
      rd_q        <= '0;
      rd_wdata_q  <= '0;
      wen_q       <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_wen_q   <= 1'b0;
      ecall_q     <= 1'b0;
      mret_q      <= 1'b0;
      mtvec_q     <= '0;
      mepc_q      <= '0;
      retire_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        pc_q        <= i_pc;
        pc_next_q   <= i_pc_next;
        pc_update_q <= i_pc_update;
        rd_q        <= i_rd;
        rd_wdata_q  <= i_rd_wdata;
        wen_q       <= i_wen;
        csr_addr_q  <= i_csr_addr;
        csr_wdata_q <= i_csr_wdata;
        csr_wen_q   <= i_csr_wen;
        ecall_q     <= i_ecall;
        mret_q      <= i_mret;
        mtvec_q     <= i_mtvec;
        mepc_q      <= i_mepc;
      end
      if (cnt_inc) retire_cnt <= retire_cnt + 1'b1;
    end
  end
  // next state and commit strobes, decoded purely from state and latched fields
  always_comb begin
    state_nx    = (commit && ecall_q) ? TRAP : xfer ? COMMIT : IDLE;
    o_gpr_wen   = commit && wen_q && !ecall_q && (rd_q != 5'd0);
    o_gpr_waddr = commit ? rd_q : 5'd0;
    o_gpr_wdata = commit ? rd_wdata_q : '0;
    o_csr_wen   = trap || (commit && (ecall_q || csr_wen_q));
    o_csr_waddr = trap ? MCAUSE_ADDR : !commit ? 12'd0 : ecall_q ? MEPC_ADDR : csr_addr_q;
    o_csr_wdata = trap ? DATA_W'(ECALL_CAUSE) : !commit ? '0 : ecall_q ? pc_q : csr_wdata_q;
    o_pc_valid  = commit && (ecall_q || mret_q || pc_update_q);
    o_pc        = !commit ? '0 : ecall_q ? mtvec_q : mret_q ? mepc_q : pc_update_q ? pc_next_q : '0;
    o_retire    = trap || (commit && !ecall_q);
  end
endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// tb_ysyx_23060124_wbu: directed self-checking bench for the write-back stage
module tb_ysyx_23060124_wbu;
  logic        clock = 1'b0, reset = 1'b1;
  logic        i_valid, o_ready;
  logic [31:0] i_pc, i_pc_next, i_rd_wdata, i_csr_wdata, i_mtvec, i_mepc;
  logic        i_pc_update, i_wen, i_csr_wen, i_ecall, i_mret;
  logic [4:0]  i_rd;
  logic [11:0] i_csr_addr;
  logic        o_gpr_wen, o_csr_wen, o_pc_valid, o_retire;
  logic [4:0]  o_gpr_waddr;
  logic [11:0] o_csr_waddr;
  logic [31:0] o_gpr_wdata, o_csr_wdata, o_pc;
  logic [63:0] o_retire_cnt;
  int errors = 0, checks = 0;

  ysyx_23060124_wbu dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_pc_next(i_pc_next), .i_pc_update(i_pc_update),
    .i_rd(i_rd), .i_rd_wdata(i_rd_wdata), .i_wen(i_wen),
    .i_csr_addr(i_csr_addr), .i_csr_wdata(i_csr_wdata), .i_csr_wen(i_csr_wen),
    .i_ecall(i_ecall), .i_mret(i_mret), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .o_gpr_wen(o_gpr_wen), .o_gpr_waddr(o_gpr_waddr), .o_gpr_wdata(o_gpr_wdata),
    .o_csr_wen(o_csr_wen), .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata),
    .o_pc_valid(o_pc_valid), .o_pc(o_pc), .o_retire(o_retire), .o_retire_cnt(o_retire_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    i_valid = 0; i_pc = 0; i_pc_next = 0; i_pc_update = 0; i_rd = 0; i_rd_wdata = 0;
    i_wen = 0; i_csr_addr = 0; i_csr_wdata = 0; i_csr_wen = 0; i_ecall = 0; i_mret = 0;
    i_mtvec = 0; i_mepc = 0;
  endtask

  task automatic gpr_in(input logic [4:0] rd, input logic [31:0] d);
    idle_in();
    i_valid = 1; i_rd = rd; i_rd_wdata = d; i_wen = 1;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic ecall_in();
    idle_in();
    i_valid = 1; i_ecall = 1; i_pc = 32'h80000010; i_mtvec = 32'h80000200;
    i_wen = 1; i_rd = 5'd3; i_rd_wdata = 32'h55; i_csr_wen = 1; i_csr_addr = 12'h300;
    i_mret = 1; i_pc_update = 1; i_pc_next = 32'h1234;
  endtask

  initial begin
    idle_in();
    #12;
    chk("rst_ready", o_ready, 1);
    chk("rst_cnt", o_retire_cnt, 0);
    chk("rst_strobes", {o_gpr_wen, o_csr_wen, o_pc_valid, o_retire}, 0);
    @(posedge clock); #1 reset = 0;
    gpr_in(5'd5, 32'h1234);
    tick();
    idle_in();
    @(negedge clock);
    chk("addi_wen", o_gpr_wen, 1);
    chk("addi_waddr", o_gpr_waddr, 5);
    chk("addi_wdata", o_gpr_wdata, 32'h1234);
    chk("addi_retire", o_retire, 1);
    chk("addi_cnt", o_retire_cnt, 1);
    chk("addi_pcv", {o_pc_valid, o_pc}, 0);
    tick();
    chk("idle_retire", {o_retire, o_gpr_wen}, 0);
    gpr_in(5'd1, 32'h10);
    tick();
    for (int i = 2; i <= 5; i++) begin
      if (i <= 4) gpr_in(5'(i), 32'(i * 16)); else idle_in();
      @(negedge clock);
      chk("b2b_ready", o_ready, 1);
      chk("b2b_wen", o_gpr_wen, 1);
      chk("b2b_waddr", o_gpr_waddr, 64'(i - 1));
      chk("b2b_wdata", o_gpr_wdata, 64'((i - 1) * 16));
      chk("b2b_cnt", o_retire_cnt, 64'(i));
      tick();
    end
    gpr_in(5'd1, 32'h80000004);
    i_pc_update = 1; i_pc_next = 32'h80000100;
    tick();
    gpr_in(5'd0, 32'hdead);
    @(negedge clock);
    chk("jal_wen", {o_gpr_wen, o_gpr_waddr}, {1'b1, 5'd1});
    chk("jal_wdata", o_gpr_wdata, 32'h80000004);
    chk("jal_redirect", {o_pc_valid, o_pc}, {1'b1, 32'h80000100});
    tick();
    idle_in();
    @(negedge clock);
    chk("x0_wen", o_gpr_wen, 0);
    chk("x0_retire", o_retire, 1);
    chk("x0_cnt", o_retire_cnt, 7);
    tick();
    ecall_in();
    tick();
    idle_in();
    @(negedge clock);
    chk("ecall_csr", {o_csr_wen, o_csr_waddr, o_csr_wdata}, {1'b1, 12'h341, 32'h80000010});
    chk("ecall_pc", {o_pc_valid, o_pc}, {1'b1, 32'h80000200});
    chk("ecall_gpr", o_gpr_wen, 0);
    chk("ecall_ready", {o_ready, o_retire}, 0);
    chk("ecall_cnt", o_retire_cnt, 7);
    tick();
    @(negedge clock);
    chk("trap_csr", {o_csr_wen, o_csr_waddr, o_csr_wdata}, {1'b1, 12'h342, 32'd11});
    chk("trap_ready", o_ready, 0);
    chk("trap_misc", {o_gpr_wen, o_pc_valid, o_retire}, 3'b001);
    chk("trap_cnt", o_retire_cnt, 8);
    tick();
    chk("post_trap", {o_ready, o_csr_wen, o_retire}, 3'b100);
    chk("post_trap_cnt", o_retire_cnt, 8);
    idle_in();
    i_valid = 1; i_mret = 1; i_pc_update = 1; i_mepc = 32'h80000014; i_pc_next = 32'h0;
    tick();
    idle_in();
    i_valid = 1; i_csr_wen = 1; i_csr_addr = 12'h305; i_csr_wdata = 32'hABC;
    @(negedge clock);
    chk("mret_pc", {o_pc_valid, o_pc}, {1'b1, 32'h80000014});
    chk("mret_cnt", o_retire_cnt, 9);
    tick();
    idle_in();
    @(negedge clock);
    chk("csrw", {o_csr_wen, o_csr_waddr, o_csr_wdata}, {1'b1, 12'h305, 32'hABC});
    chk("csrw_pcv", o_pc_valid, 0);
    chk("csrw_cnt", o_retire_cnt, 10);
    tick();
    ecall_in();
    tick();
    idle_in();
    tick();
    chk("pre_rst_trap", o_csr_wen, 1);
    #1 reset = 1;
    #1;
    chk("arst_strobes", {o_csr_wen, o_retire, o_gpr_wen, o_pc_valid}, 0);
    chk("arst_cnt", o_retire_cnt, 0);
    chk("arst_ready", o_ready, 1);
    #1 reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("arst_no_mcause", {o_csr_wen, o_retire}, 0);
    end
    tick();
    force dut.retire_cnt = {64{1'b1}};
    #1 release dut.retire_cnt;
    chk("preload", o_retire_cnt, {64{1'b1}});
    gpr_in(5'd7, 32'h77);
    tick();
    idle_in();
    @(negedge clock);
    chk("wrap_cnt", o_retire_cnt, 0);
    chk("wrap_retire", o_retire, 1);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
